// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-ALU sequencer: op encodings, widths, FSM states.
// Also holds the per-nibble carry/borrow derivation used by the controller.
package alu_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_FIX,
        ST_DONE
    } state_e;

    // The ALU has no carry output, so it is recovered from operands and sum.
    function automatic logic nib_carry(input logic [1:0] op,
                                       input logic [NIBBLE_W-1:0] o,
                                       input logic [NIBBLE_W-1:0] a,
                                       input logic [NIBBLE_W-1:0] b);
        logic cy;
        cy = 1'b0;
        if (op == ALU_ADD)      cy = (o < a);
        else if (op == ALU_SUB) cy = (a < b);
        return cy;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Purpose: runs 8-bit ADD/SUB/AND/NOT as low/high/fix passes over a shared 4-bit ALU.
// Latency: response 4 cycles after accept (AND/NOT 3); with ALU_SEQ_SKIP_EN, ADD/SUB take 3 when no low carry.
// Backpressure: holds result in DONE until rsp_ready; req_ready only while idle.
module alu_seq_ctrl
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [WORD_W-1:0]   req_a,
    input  logic [WORD_W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORD_W-1:0]   rsp_result,
    output logic                rsp_carry,
    output logic                rsp_zero,
    output logic [NIBBLE_W-1:0] alu_x,
    output logic [NIBBLE_W-1:0] alu_y,
    output logic [1:0]          alu_op,
    input  logic [NIBBLE_W-1:0] alu_o
);

`ifdef ALU_SEQ_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [WORD_W-1:0]   a_q, a_d, b_q, b_d;
    logic [NIBBLE_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic                c_q, c_d, ch_q, ch_d;
    logic                carry_q, carry_d, zero_q, zero_d;
    logic [NIBBLE_W-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
    logic [1:0]          alu_op_q, alu_op_d;
    logic                ch_now;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        c_d      = c_q;
        ch_d     = ch_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        alu_x_d  = alu_x_q;
        alu_y_d  = alu_y_q;
        alu_op_d = alu_op_q;
        ch_now   = nib_carry(op_q, alu_o, a_q[7:4], b_q[7:4]);

        // ALU drive is registered, so each state loads the operands for the next pass.
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_LO;
                    op_d     = req_op;
                    a_d      = req_a;
                    b_d      = req_b;
                    alu_x_d  = req_a[3:0];
                    alu_y_d  = req_b[3:0];
                    alu_op_d = req_op;
                end
            end
            ST_LO: begin
                lo_d    = alu_o;
                c_d     = nib_carry(op_q, alu_o, a_q[3:0], b_q[3:0]);
                alu_x_d = a_q[7:4];
                alu_y_d = b_q[7:4];
                state_d = ST_HI;
            end
            ST_HI: begin
                hi_d = alu_o;
                ch_d = ch_now;
                if (op_q == ALU_AND || op_q == ALU_NOT || (SKIP_EN && !c_q)) begin
                    state_d  = ST_DONE;
                    carry_d  = ch_now;
                    zero_d   = ({alu_o, lo_q} == '0);
                    alu_x_d  = '0;
                    alu_y_d  = '0;
                    alu_op_d = ALU_ADD;
                end else begin
                    state_d = ST_FIX;
                    alu_x_d = alu_o;
                    alu_y_d = {3'b000, c_q};
                end
            end
            ST_FIX: begin
                hi_d     = alu_o;
                carry_d  = ch_q | (c_q & ((op_q == ALU_ADD) ? (alu_o == '0) : (hi_q == '0)));
                zero_d   = ({alu_o, lo_q} == '0);
                alu_x_d  = '0;
                alu_y_d  = '0;
                alu_op_d = ALU_ADD;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            c_q      <= 1'b0;
            ch_q     <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            alu_x_q  <= '0;
            alu_y_q  <= '0;
            alu_op_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            c_q      <= c_d;
            ch_q     <= ch_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            alu_x_q  <= alu_x_d;
            alu_y_q  <= alu_y_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_result = {hi_q, lo_q};
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: fixed vectors, randomized ops against an 8-bit arithmetic model,
// back-pressure, busy-request and mid-operation reset sequences.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

`ifdef ALU_SEQ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int NC_LAT = SKIP ? 3 : 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0] req_op, alu_op;
    logic [7:0] req_a, req_b, rsp_result;
    logic       rsp_carry, rsp_zero;
    logic [3:0] alu_x, alu_y, alu_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Combinational nibble ALU living beside the controller.
    always_comb begin
        alu_o = '0;
        case (alu_op)
            ALU_ADD: alu_o = alu_x + alu_y;
            ALU_SUB: alu_o = alu_x - alu_y;
            ALU_AND: alu_o = alu_x & alu_y;
            default: alu_o = ~alu_x;
        endcase
    end

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_o(alu_o)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b, res;
        logic       cy, z;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-word reference: results from 8/9-bit arithmetic, latency from the low-nibble carry.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic cy, output logic z, output int lat);
        logic [8:0] s;
        logic       lowc;
        lowc = 1'b0;
        cy   = 1'b0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cy = s[8];
                lowc = (int'(a[3:0]) + int'(b[3:0])) > 15;
            end
            ALU_SUB: begin
                r = a - b; cy = (a < b);
                lowc = (a[3:0] < b[3:0]);
            end
            ALU_AND: r = a & b;
            default: r = ~a;
        endcase
        z = (r == 8'h00);
        if (op == ALU_AND || op == ALU_NOT) lat = 3;
        else lat = (SKIP && !lowc) ? 3 : 4;
    endtask

    // Called on a negedge with the controller idle; returns on a negedge, idle again.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int hold, input logic [7:0] er,
                          input logic ecy, input logic ez, input int elat);
        int lat;
        bit got;
        chk({tag, " idle_rdy"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(negedge clk);
        lat = 1;
        got = 0;
        while (lat <= 20) begin
            if (rsp_valid) begin got = 1; break; end
            chk({tag, " busy_rdy"}, req_ready, 0);
            req_op = 2'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!got) begin
            chk({tag, " timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        chk({tag, " latency"}, lat, elat);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, " result"}, rsp_result, er);
            chk({tag, " carry"}, rsp_carry, ecy);
            chk({tag, " zero"}, rsp_zero, ez);
            chk({tag, " valid"}, rsp_valid, 1);
            chk({tag, " done_rdy"}, req_ready, 0);
            chk({tag, " alu_idle"}, {alu_x, alu_y, alu_op}, 0);
            if (h < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, " rsp_drop"}, rsp_valid, 0);
        chk({tag, " no_accept"}, req_ready, 1);
    endtask

    initial begin
        logic [7:0] r;
        logic       cy, z;
        int         lat;
        logic [1:0] op;
        logic [7:0] a, b;

        tbl[0] = '{ALU_ADD, 8'h3A, 8'h47, 8'h81, 1'b0, 1'b0, 4};
        tbl[1] = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 4};
        tbl[2] = '{ALU_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 4};
        tbl[3] = '{ALU_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 4};
        tbl[4] = '{ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 3};
        tbl[5] = '{ALU_NOT, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0, 3};
        tbl[6] = '{ALU_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, NC_LAT};
        tbl[7] = '{ALU_SUB, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, NC_LAT};
        tbl[8] = '{ALU_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, NC_LAT};

        req_valid = 0; rsp_ready = 0; req_op = 0; req_a = 0; req_b = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset req_ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset flags", {rsp_carry, rsp_zero}, 0);
        chk("reset alu", {alu_x, alu_y, alu_op}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, i % 2,
                   tbl[i].res, tbl[i].cy, tbl[i].z, tbl[i].lat);

        // Long back-pressure on NOT: req_b toggles during busy/hold and must not matter.
        run_op("bp_not", ALU_NOT, 8'h0F, 8'hFF, 3, 8'hF0, 1'b0, 1'b0, 3);

        // Reset while the high nibble pass is in flight.
        req_valid = 1'b1; req_op = ALU_ADD; req_a = 8'h33; req_b = 8'h44;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", rsp_valid, 0);
        chk("midrst rsp_result", rsp_result, 0);
        chk("midrst flags", {rsp_carry, rsp_zero}, 0);
        chk("midrst alu", {alu_x, alu_y, alu_op}, 0);
        chk("midrst req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", ALU_ADD, 8'h01, 8'h01, 0, 8'h02, 1'b0, 1'b0, NC_LAT);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (i % 10 == 0) b = a;
            model(op, a, b, r, cy, z, lat);
            run_op($sformatf("rnd%0d", i), op, a, b, int'($urandom_range(0, 2)), r, cy, z, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
